wbvidarb: RTL and testbench

Two-master Wishbone (pipelined) arbiter that shares the single external memory bus between the video frame reader (master A, read-only refill of the display FIFO) and the spectrogram writer (master B, line writes into the frame buffer). It sits between those two masters and the memory slave in the `i_clk` domain. It gives master A priority so display underflow is avoided, holds a grant for a whole bus cycle, and optionally aborts hung cycles with a bus timeout.

---
 rtl/wbvidarb_pkg.sv | 28 ++
 rtl/wbvidarb_timeout.sv | 30 +++
 rtl/wbvidarb.sv | 191 +++++++++++++++++++
 tb/tb_wbvidarb.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbvidarb_pkg.sv
// wbvidarb_pkg: shared state encodings, owner select, default bus widths
// and the priority arbitration helper for the wbvidarb bus arbiter.
package wbvidarb_pkg;

  localparam int unsigned WB_AW = 24;
  localparam int unsigned WB_DW = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GNT_A = 2'd1;
  localparam state_t ST_GNT_B = 2'd2;
  localparam state_t ST_ABORT = 2'd3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  // Video master A always wins so the display FIFO is refilled first.
  function automatic state_t arb_next(input logic a_cyc, input logic b_cyc);
    if (a_cyc)      return ST_GNT_A;
    else if (b_cyc) return ST_GNT_B;
    else            return ST_IDLE;
  endfunction

endpackage

// File: rtl/wbvidarb_timeout.sv
// wbvidarb_timeout: bus-cycle watchdog. Counts cycles with no bus progress
// and flags saturation; the counter holds at all-ones until cleared.
module wbvidarb_timeout #(
  parameter int unsigned LG = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sat
);

  logic [LG-1:0] cnt_q, cnt_d;

  // Clear on progress, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)     cnt_d = '0;
    else if (i_en) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign o_sat = &cnt_q;

endmodule

// File: rtl/wbvidarb.sv
// wbvidarb: two-master pipelined Wishbone arbiter. Master A (video reader)
// has priority over master B (spectrogram writer); a grant is held for the
// whole bus cycle. Define WBVIDARB_TIMEOUT_EN to add the hung-cycle timeout
// and ABORT state; without it ABORT is unreachable and TIMEOUT_LG is unused.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no owner, both masters stalled, arbitrate every edge
// GNT_A    | master A owns the bus until i_a_cyc drops
// GNT_B    | master B owns the bus until i_b_cyc drops
// ABORT    | timed-out cycle killed; wait for former owner to drop cyc
module wbvidarb
  import wbvidarb_pkg::*;
#(
  parameter int unsigned AW         = WB_AW,
  parameter int unsigned DW         = WB_DW,
  parameter int unsigned TIMEOUT_LG = 10
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_ack,
  input  logic            i_stall,
  input  logic            i_err,
  input  logic [DW-1:0]   i_data,
  output logic [DW-1:0]   o_rdata
);

  if (TIMEOUT_LG < 2) begin : g_bad_lg
    $error("wbvidarb: TIMEOUT_LG must be at least 2");
  end

  state_t state_q, state_d;
  logic   abort_b_q, abort_b_d;
  owner_e owner;
  logic   own_cyc;
  logic   own_stb;
  logic   tmo_sat;
  logic   tmo_fire;

  // Decode the current owner; ABORT has no owner so stale acks are dropped.
  always_comb begin
    owner = OWN_NONE;
    case (state_q)
      ST_GNT_A: owner = OWN_A;
      ST_GNT_B: owner = OWN_B;
      default:  owner = OWN_NONE;
    endcase
  end

  // Master-to-slave mux; everything is zero when nobody owns the bus.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    o_we    = 1'b0;
    o_addr  = '0;
    o_data  = '0;
    o_sel   = '0;
    case (owner)
      OWN_A: begin
        own_cyc = i_a_cyc;
        own_stb = i_a_stb;
        o_we    = i_a_we;
        o_addr  = i_a_addr;
        o_data  = i_a_data;
        o_sel   = i_a_sel;
      end
      OWN_B: begin
        own_cyc = i_b_cyc;
        own_stb = i_b_stb;
        o_we    = i_b_we;
        o_addr  = i_b_addr;
        o_data  = i_b_data;
        o_sel   = i_b_sel;
      end
      default: ;
    endcase
  end

  assign o_cyc   = own_cyc;
  assign o_stb   = own_stb;
  assign o_rdata = i_data;

`ifdef WBVIDARB_TIMEOUT_EN
  logic tmo_clr;

  assign tmo_clr = !o_cyc || i_ack || i_err || (o_stb && !i_stall);

  wbvidarb_timeout #(
    .LG (TIMEOUT_LG)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (tmo_clr),
    .i_en      (!tmo_sat),
    .o_sat     (tmo_sat)
  );
`else
  assign tmo_sat = 1'b0;
`endif

  // An owner dropping cyc in the saturate cycle is a normal release, not an abort.
  assign tmo_fire = tmo_sat && own_cyc;

  // Slave responses reach only the owner; a timeout adds a one-cycle err.
  always_comb begin
    o_a_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    case (owner)
      OWN_A: begin
        o_a_stall = i_stall;
        o_a_ack   = i_ack;
        o_a_err   = i_err || tmo_fire;
      end
      OWN_B: begin
        o_b_stall = i_stall;
        o_b_ack   = i_ack;
        o_b_err   = i_err || tmo_fire;
      end
      default: ;
    endcase
  end

  // Next-state: re-arbitrate whenever the owner releases, giving a direct hand-off.
  always_comb begin
    state_d   = state_q;
    abort_b_d = abort_b_q;
    case (state_q)
      ST_IDLE: state_d = arb_next(i_a_cyc, i_b_cyc);
      ST_GNT_A: begin
        if (!i_a_cyc) begin
          state_d = arb_next(i_a_cyc, i_b_cyc);
        end else if (tmo_fire) begin
          state_d   = ST_ABORT;
          abort_b_d = 1'b0;
        end
      end
      ST_GNT_B: begin
        if (!i_b_cyc) begin
          state_d = arb_next(i_a_cyc, i_b_cyc);
        end else if (tmo_fire) begin
          state_d   = ST_ABORT;
          abort_b_d = 1'b1;
        end
      end
      ST_ABORT: begin
        if (abort_b_q ? !i_b_cyc : !i_a_cyc) state_d = arb_next(i_a_cyc, i_b_cyc);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset releases the bus immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      abort_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      abort_b_q <= abort_b_d;
    end
  end

endmodule

// File: tb/tb_wbvidarb.sv
// tb_wbvidarb: directed stimulus with a scoreboard. Master tasks push the
// expected slave transactions and read responses when a strobe is accepted;
// a monitor pops and compares whenever the DUT presents them.
module tb_wbvidarb;
  import wbvidarb_pkg::*;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  logic [SW-1:0] m_sel [2];

  logic          o_a_ack, o_a_stall, o_a_err;
  logic          o_b_ack, o_b_stall, o_b_err;
  logic          o_cyc, o_stb, o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [SW-1:0] o_sel;
  logic          i_ack, i_stall, i_err;
  logic [DW-1:0] i_data;
  logic [DW-1:0] o_rdata;

  wbvidarb #(.AW(AW), .DW(DW), .TIMEOUT_LG(4)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_a_cyc   (m_cyc[0]),
    .i_a_stb   (m_stb[0]),
    .i_a_we    (m_we[0]),
    .i_a_addr  (m_addr[0]),
    .i_a_data  (m_data[0]),
    .i_a_sel   (m_sel[0]),
    .o_a_ack   (o_a_ack),
    .o_a_stall (o_a_stall),
    .o_a_err   (o_a_err),
    .i_b_cyc   (m_cyc[1]),
    .i_b_stb   (m_stb[1]),
    .i_b_we    (m_we[1]),
    .i_b_addr  (m_addr[1]),
    .i_b_data  (m_data[1]),
    .i_b_sel   (m_sel[1]),
    .o_b_ack   (o_b_ack),
    .o_b_stall (o_b_stall),
    .o_b_err   (o_b_err),
    .o_cyc     (o_cyc),
    .o_stb     (o_stb),
    .o_we      (o_we),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .o_sel     (o_sel),
    .i_ack     (i_ack),
    .i_stall   (i_stall),
    .i_err     (i_err),
    .i_data    (i_data),
    .o_rdata   (o_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc_no = 0;
  always @(posedge i_clk) cyc_no++;

  int n_checks = 0;
  int n_pass   = 0;

  logic [60:0]   exp_slv[$];
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  logic [DW-1:0] got_a[$];

  bit sb_en        = 1'b1;
  bit chk_b_stall  = 1'b0;
  bit slave_ack_en = 1'b1;
  bit slave_err    = 1'b0;
  bit force_ack    = 1'b0;
  bit stall_en     = 1'b0;
  int a_err_cnt    = 0;
  int b_err_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string detail);
    n_checks++;
    $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = DW'(a) + 32'd1;
    return w * 32'h11;
  endfunction

  function automatic logic [DW-1:0] wr_word(input int m, input logic [AW-1:0] a);
    return {(m == 1) ? 8'hB0 : 8'hA0, a};
  endfunction

  // Slave: ack (or one-shot err) one cycle after each accepted strobe.
  initial begin
    bit            acc;
    logic [AW-1:0] acc_addr;
    i_ack = 1'b0; i_err = 1'b0; i_stall = 1'b0; i_data = '0;
    forever begin
      @(negedge i_clk);
      acc      = o_cyc && o_stb && !i_stall;
      acc_addr = o_addr;
      @(posedge i_clk); #1;
      i_ack   = (acc && slave_ack_en && !slave_err) || force_ack;
      i_err   = acc && slave_err;
      if (acc && slave_err) slave_err = 1'b0;
      force_ack = 1'b0;
      i_data  = acc ? rd_word(acc_addr) : '0;
      i_stall = stall_en && (cyc_no % 3 == 1);
    end
  end

  // Monitor: pops expectations when the DUT presents a transaction or ack.
  initial begin
    forever begin
      @(negedge i_clk); #2;
      if (sb_en) begin
        if (o_cyc && o_stb && !i_stall) begin
          if (exp_slv.size() == 0) fail_now("slave_txn", $sformatf("unexpected addr %0h", o_addr));
          else check("slave_txn", {o_we, o_addr, o_data, o_sel}, exp_slv.pop_front());
        end
        if (o_a_ack) begin
          got_a.push_back(o_rdata);
          if (exp_a.size() == 0) fail_now("a_ack", "unexpected ack to A");
          else check("a_rdata", o_rdata, exp_a.pop_front());
        end
        if (o_b_ack) begin
          if (exp_b.size() == 0) fail_now("b_ack", "unexpected ack to B");
          else check("b_rdata", o_rdata, exp_b.pop_front());
        end
        if (o_a_err) a_err_cnt++;
        if (o_b_err) b_err_cnt++;
        if (chk_b_stall) check("b_stall_during_a", o_b_stall, 1);
      end
    end
  end

  task automatic burst(input int m, input bit we, input logic [AW-1:0] base, input int n);
    int sent, acked, guard;
    bit st, ak, er, done;
    sent = 0; acked = 0; guard = 0; done = 1'b0;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_addr[m] = base; m_data[m] = wr_word(m, base);
    m_sel[m] = (m == 1) ? 4'h3 : 4'hF;
    while (!done) begin
      @(negedge i_clk);
      st = (m == 1) ? o_b_stall : o_a_stall;
      ak = (m == 1) ? o_b_ack   : o_a_ack;
      er = (m == 1) ? o_b_err   : o_a_err;
      if (m_stb[m] && !st) begin
        exp_slv.push_back({m_we[m], m_addr[m], m_data[m], m_sel[m]});
        if (m == 1) exp_b.push_back(rd_word(m_addr[m]));
        else        exp_a.push_back(rd_word(m_addr[m]));
        sent++;
      end
      if (ak) acked++;
      if (er) begin
        if (m == 1) exp_b.delete();
        else        exp_a.delete();
        done = 1'b1;
      end
      if (acked >= n) done = 1'b1;
      guard++;
      if (guard > 200 && !done) begin
        fail_now("burst_timeout", $sformatf("master %0d sent %0d acked %0d of %0d", m, sent, acked, n));
        done = 1'b1;
      end
      @(posedge i_clk); #1;
      if (!done && sent < n) begin
        m_addr[m] = base + AW'(sent);
        m_data[m] = wr_word(m, base + AW'(sent));
      end else begin
        m_stb[m] = 1'b0;
      end
    end
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_fall, b_first, k_err;
    bit prev_a, prev_b, found;

    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_addr[i] = '0; m_data[i] = '0; m_sel[i] = '0;
    end

    // Reset with A requesting: nothing may leak to the slave.
    i_reset_n = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 24'h000123;
    #12;
    check("rst_o_cyc", o_cyc, 0);
    check("rst_o_stb", o_stb, 0);
    check("rst_o_addr", o_addr, 0);
    check("rst_a_stall", o_a_stall, 1);
    check("rst_b_stall", o_b_stall, 1);
    check("rst_a_ack", o_a_ack, 0);
    check("rst_a_err", o_a_err, 0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_addr[0] = '0;
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk); #1;

    // A reads 4 words; B stays stalled; read data 0x11..0x44.
    got_a.delete();
    chk_b_stall = 1'b1;
    burst(0, 1'b0, 24'h000000, 4);
    chk_b_stall = 1'b0;
    check("a_read_count", got_a.size(), 4);
    if (got_a.size() == 4) begin
      check("a_rdata0", got_a[0], 32'h11);
      check("a_rdata1", got_a[1], 32'h22);
      check("a_rdata2", got_a[2], 32'h33);
      check("a_rdata3", got_a[3], 32'h44);
    end
    repeat (2) @(posedge i_clk); #1;

    // Simultaneous requests: A first, B's stb one cycle after A's cyc falls.
    a_fall = -1; b_first = -1;
    fork
      burst(0, 1'b0, 24'h000010, 2);
      burst(1, 1'b1, 24'h000020, 2);
      begin
        prev_a = 1'b1;
        for (int k = 0; k < 100 && b_first < 0; k++) begin
          @(negedge i_clk); #3;
          if (prev_a && !m_cyc[0] && a_fall < 0) a_fall = cyc_no;
          prev_a = m_cyc[0];
          if (o_stb && o_addr == 24'h000020 && b_first < 0) b_first = cyc_no;
        end
      end
    join
    check("a_first_seen", (a_fall >= 0), 1);
    check("handoff_gap", 64'(b_first - a_fall), 64'd1);
    repeat (2) @(posedge i_clk); #1;

    // B writes 8 words with slave stalls; A requests mid-burst and must wait.
    stall_en = 1'b1;
    a_fall = -1; b_first = -1;
    fork
      burst(1, 1'b1, 24'h000040, 8);
      begin
        repeat (3) @(posedge i_clk); #1;
        burst(0, 1'b0, 24'h000080, 1);
      end
      begin
        prev_b = 1'b1;
        for (int k = 0; k < 150 && b_first < 0; k++) begin
          @(negedge i_clk); #3;
          if (m_cyc[1] && m_cyc[0]) check("a_stall_while_b", o_a_stall, 1);
          if (m_cyc[1] && o_stb && o_addr == 24'h000080) fail_now("a_leak", "A strobe reached slave during B cycle");
          if (prev_b && !m_cyc[1] && a_fall < 0) a_fall = cyc_no;
          prev_b = m_cyc[1];
          if (o_stb && o_addr == 24'h000080 && b_first < 0) b_first = cyc_no;
        end
      end
    join
    stall_en = 1'b0;
    check("b_to_a_handoff", 64'(b_first - a_fall), 64'd1);
    repeat (2) @(posedge i_clk); #1;

    // Slave err on B: one-cycle err to B only, then A gets the bus.
    a_err_cnt = 0; b_err_cnt = 0;
    slave_err = 1'b1;
    fork
      burst(1, 1'b1, 24'h000060, 1);
      begin
        @(posedge i_clk); #1;
        burst(0, 1'b0, 24'h000004, 1);
      end
    join
    check("b_err_pulses", b_err_cnt, 1);
    check("a_err_pulses", a_err_cnt, 0);
    repeat (2) @(posedge i_clk); #1;

`ifdef WBVIDARB_TIMEOUT_EN
    // Hung slave: err 15 idle cycles after acceptance, then ABORT.
    sb_en = 1'b0;
    slave_ack_en = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 24'h000200; m_sel[0] = 4'hF;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge i_clk); #3;
      if (o_stb && !o_a_stall) found = 1'b1;
    end
    check("tmo_accept", found, 1);
    @(posedge i_clk); #1;
    m_stb[0] = 1'b0;
    k_err = -1;
    for (int k = 1; k <= 40 && k_err < 0; k++) begin
      @(negedge i_clk); #3;
      if (o_a_err) k_err = k;
    end
    // 15 idle cycles follow the accepting edge; err shows in the next one.
    check("tmo_latency", 64'(k_err), 64'd16);
    check("tmo_b_err", o_b_err, 0);
    @(negedge i_clk); #3;
    check("tmo_err_pulse", o_a_err, 0);
    check("abort_o_cyc", o_cyc, 0);
    check("abort_a_stall", o_a_stall, 1);
    force_ack = 1'b1;
    @(negedge i_clk); #3;
    check("stale_ack_dropped", o_a_ack, 0);
    slave_ack_en = 1'b1;
    sb_en = 1'b1;
    fork
      begin
        @(posedge i_clk); #1;
        m_cyc[0] = 1'b0;
      end
      burst(1, 1'b1, 24'h000300, 1);
    join
    repeat (2) @(posedge i_clk); #1;
`endif

    // Reset while B is mid-burst: bus drops at once, B re-granted after release.
    sb_en = 1'b0;
    @(posedge i_clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_addr[1] = 24'h000100; m_data[1] = wr_word(1, 24'h000100); m_sel[1] = 4'h3;
    repeat (3) @(posedge i_clk);
    #3;
    check("pre_rst_o_cyc", o_cyc, 1);
    i_reset_n = 1'b0;
    #1;
    check("midrst_o_cyc", o_cyc, 0);
    check("midrst_a_stall", o_a_stall, 1);
    check("midrst_b_stall", o_b_stall, 1);
    check("midrst_b_ack", o_b_ack, 0);
    repeat (2) @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(negedge i_clk); #3;
    check("post_rst_idle", o_cyc, 0);
    @(negedge i_clk); #3;
    check("regrant_o_cyc", o_cyc, 1);
    check("regrant_addr", o_addr, 24'h000100);
    @(posedge i_clk); #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (3) @(posedge i_clk); #1;
    exp_slv.delete(); exp_a.delete(); exp_b.delete();
    sb_en = 1'b1;

    check("exp_slv_empty", exp_slv.size(), 0);
    check("exp_a_empty", exp_a.size(), 0);
    check("exp_b_empty", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
